// File: rtl/fsm_run_ctrl_pkg.sv
// Shared encodings for the lap-run controller
// and its benches.
package fsm_run_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_FLUSH = 2'b10,
    S_DONE  = 2'b11
  } state_t;

  localparam int NREQ = 2;

  localparam logic [1:0] FSM_FIRST  = 2'b11;
  localparam logic [1:0] FSM_SECOND = 2'b01;
  localparam logic [1:0] FSM_THIRD  = 2'b10;

endpackage

// File: rtl/fsm_run_ctrl_rr_arb2.sv
// Two-way round-robin pick; on a tie the
// requester that was not served last wins.
module rr_arb2
  import fsm_run_ctrl_pkg::*;
(
  input  logic [NREQ-1:0] req,
  input  logic            last,
  output logic [NREQ-1:0] win
);

  always_comb begin
    win = '0;
    unique case (req)
      2'b01:   win = 2'b01;
      2'b10:   win = 2'b10;
      2'b11:   win = last ? 2'b01 : 2'b10;
      default: win = '0;
    endcase
  end

endmodule

// File: rtl/fsm_run_ctrl.sv
// Grants the lap FSM to one of two requesters
// and counts its terminal events down to done.
module fsm_run_ctrl
  import fsm_run_ctrl_pkg::*;
#(
  parameter int LAP_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req,
  input  logic [LAP_W-1:0] laps0,
  input  logic [LAP_W-1:0] laps1,
  input  logic             hold,
  input  logic             abort,
  input  logic             terminal,
  output logic             fsm_pause,
  output logic             fsm_restart,
  output logic [1:0]       gnt,
  output logic [1:0]       done,
  output logic             aborted,
  output logic             busy,
  output logic [LAP_W-1:0] laps_left
);

  state_t           r_state, w_nxt;
  logic             r_last, w_last;
  logic [1:0]       r_gnt, w_gnt;
  logic [LAP_W-1:0] r_laps, w_laps;
  logic             r_abt, w_abt;
  logic [1:0]       w_win;

  rr_arb2 u_arb (
    .req  (req),
    .last (r_last),
    .win  (w_win)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_last  <= 1'b1;
      r_gnt   <= '0;
      r_laps  <= '0;
      r_abt   <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_last  <= w_last;
      r_gnt   <= w_gnt;
      r_laps  <= w_laps;
      r_abt   <= w_abt;
    end
  end

  // Pause/restart never look at terminal,
  // so there is no loop through the FSM.
  always_comb begin
    w_nxt       = r_state;
    w_last      = r_last;
    w_gnt       = r_gnt;
    w_laps      = r_laps;
    w_abt       = r_abt;
    fsm_pause   = 1'b1;
    fsm_restart = 1'b1;
    done        = '0;
    aborted     = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (|req) begin
          w_gnt  = w_win;
          w_last = w_win[1];
          w_laps = w_win[1] ? laps1 : laps0;
          w_nxt  = (w_laps == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        fsm_restart = 1'b0;
        fsm_pause   = hold;
        if (abort) begin
          w_nxt = S_FLUSH;
        end else if (terminal) begin
          w_laps = r_laps - 1'b1;
          if (r_laps == LAP_W'(1))
            w_nxt = S_DONE;
        end
      end
      S_FLUSH: begin
        w_abt = 1'b1;
        w_nxt = S_DONE;
      end
      S_DONE: begin
        done    = r_gnt;
        aborted = r_abt;
        w_gnt   = '0;
        w_abt   = 1'b0;
        w_nxt   = S_IDLE;
      end
      default: w_nxt = S_IDLE;
    endcase
  end

  assign gnt       = r_gnt;
  assign busy      = (r_state != S_IDLE);
  assign laps_left = r_laps;

endmodule

// File: tb/tb_fsm_run_ctrl.sv
// Scoreboard bench for fsm_run_ctrl driving
// a behavioural model of the lap FSM.
module tb_fsm_run_ctrl;
  import fsm_run_ctrl_pkg::*;

  localparam int LW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [1:0]    req = '0;
  logic [LW-1:0] laps0 = '0;
  logic [LW-1:0] laps1 = '0;
  logic          hold = 1'b0;
  logic          abort = 1'b0;
  logic          terminal;
  logic          fsm_pause, fsm_restart;
  logic [1:0]    gnt, done;
  logic          aborted, busy;
  logic [LW-1:0] laps_left;

  fsm_run_ctrl #(.LAP_W(LW)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .laps0       (laps0),
    .laps1       (laps1),
    .hold        (hold),
    .abort       (abort),
    .terminal    (terminal),
    .fsm_pause   (fsm_pause),
    .fsm_restart (fsm_restart),
    .gnt         (gnt),
    .done        (done),
    .aborted     (aborted),
    .busy        (busy),
    .laps_left   (laps_left)
  );

  always #5 clk = ~clk;

  // Lap FSM: FIRST -> SECOND -> THIRD -> FIRST
  logic [1:0] fs = FSM_FIRST;
  always @(posedge clk) begin
    if (fsm_restart)
      fs <= FSM_FIRST;
    else if (!fsm_pause)
      unique case (fs)
        FSM_FIRST:  fs <= FSM_SECOND;
        FSM_SECOND: fs <= FSM_THIRD;
        default:    fs <= FSM_FIRST;
      endcase
  end
  assign terminal = (fs == FSM_THIRD) &&
                    !fsm_pause && !fsm_restart;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s obs=%0h exp=%0h",
               tag, obs, exp);
    end
  endtask

  typedef struct {
    logic [1:0] d;
    logic       a;
  } exp_t;
  exp_t q[$];

  always @(negedge clk) begin
    if (done != 2'b00) begin
      if (q.size() == 0) begin
        chk("sb_extra_done", 32'(done), 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("sb_done", 32'(done), 32'(e.d));
        chk("sb_aborted", 32'(aborted), 32'(e.a));
      end
    end
  end

  logic [LW-1:0] lv [32];
  logic [1:0]    fv [32];
  logic [1:0]    gv [32];
  logic          rv [32];
  logic          pv [32];

  task automatic push(input logic [1:0] d,
                      input logic a);
    exp_t e;
    e.d = d;
    e.a = a;
    q.push_back(e);
  endtask

  task automatic run(input int hlo, input int hhi,
                     input int ab, input int lim,
                     output int gcyc, output int dcyc,
                     output int tmask);
    gcyc = 0;
    dcyc = 0;
    tmask = 0;
    for (int c = 1; c <= lim; c++) begin
      @(negedge clk);
      hold  = (c >= hlo) && (c <= hhi);
      abort = (c == ab);
      #1;
      lv[c] = laps_left;
      fv[c] = fs;
      gv[c] = gnt;
      rv[c] = fsm_restart;
      pv[c] = fsm_pause;
      if (gcyc == 0 && gnt != 2'b00) gcyc = c;
      if (terminal) tmask |= (1 << c);
      if (done != 2'b00) begin
        dcyc = c;
        req  = req & ~done;
        break;
      end
    end
    hold  = 1'b0;
    abort = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    hold = 1'b0;
    abort = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_laps", 32'(laps_left), 32'd0);
    chk("rst_restart", 32'(fsm_restart), 32'd1);
    chk("rst_pause", 32'(fsm_pause), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    rst = 1'b0;
  endtask

  int g, d, t;

  initial begin
    do_reset();

    // single run, 2 laps
    laps0 = 8'd2;
    req = 2'b01;
    push(2'b01, 1'b0);
    run(0, -1, 0, 30, g, d, t);
    chk("t1_gcyc", 32'(g), 32'd1);
    chk("t1_gnt", 32'(gv[1]), 32'd1);
    chk("t1_term", 32'(t), 32'((1 << 3) | (1 << 6)));
    chk("t1_laps_c1", 32'(lv[1]), 32'd2);
    chk("t1_laps_c4", 32'(lv[4]), 32'd1);
    chk("t1_laps_c7", 32'(lv[7]), 32'd0);
    chk("t1_fs_c2", 32'(fv[2]), 32'(FSM_SECOND));
    chk("t1_restart", 32'(rv[2]), 32'd0);
    chk("t1_dcyc", 32'(d), 32'd7);
    req = '0;
    @(negedge clk);

    // contention from reset
    do_reset();
    laps0 = 8'd1;
    laps1 = 8'd1;
    req = 2'b11;
    push(2'b01, 1'b0);
    push(2'b10, 1'b0);
    run(0, -1, 0, 30, g, d, t);
    chk("t2a_gnt", 32'(gv[1]), 32'd1);
    chk("t2a_dcyc", 32'(d), 32'd4);
    chk("t2a_req", 32'(req), 32'd2);
    run(0, -1, 0, 30, g, d, t);
    chk("t2b_gcyc", 32'(g), 32'd2);
    chk("t2b_gnt", 32'(gv[2]), 32'd2);
    chk("t2b_dcyc", 32'(d), 32'd5);
    req = 2'b11;
    push(2'b01, 1'b0);
    run(0, -1, 0, 30, g, d, t);
    chk("t2c_gnt", 32'(gv[2]), 32'd1);
    chk("t2c_dcyc", 32'(d), 32'd5);
    req = '0;
    @(negedge clk);

    // hold on RUN cycles 2..4
    laps0 = 8'd1;
    req = 2'b01;
    push(2'b01, 1'b0);
    run(2, 4, 0, 30, g, d, t);
    chk("t3_pause", 32'(pv[3]), 32'd1);
    chk("t3_fs_c5", 32'(fv[5]), 32'(FSM_SECOND));
    chk("t3_term", 32'(t), 32'(1 << 6));
    chk("t3_dcyc", 32'(d), 32'd7);
    req = '0;
    @(negedge clk);

    // abort on first terminal
    laps1 = 8'd3;
    req = 2'b10;
    push(2'b10, 1'b1);
    run(0, -1, 3, 30, g, d, t);
    chk("t4_gnt", 32'(gv[1]), 32'd2);
    chk("t4_term", 32'(t[3]), 32'd1);
    chk("t4_laps", 32'(lv[4]), 32'd3);
    chk("t4_flush_rst", 32'(rv[4]), 32'd1);
    chk("t4_fs_c5", 32'(fv[5]), 32'(FSM_FIRST));
    chk("t4_dcyc", 32'(d), 32'd5);
    req = '0;
    @(negedge clk);

    // zero laps
    laps1 = 8'd0;
    req = 2'b10;
    push(2'b10, 1'b0);
    run(0, -1, 0, 10, g, d, t);
    chk("t5_gcyc", 32'(g), 32'd1);
    chk("t5_dcyc", 32'(d), 32'd1);
    chk("t5_fs", 32'(fv[1]), 32'(FSM_FIRST));
    req = '0;
    @(negedge clk);
    #1;
    chk("t5_fs_after", 32'(fs), 32'(FSM_FIRST));

    // reset mid-run
    @(negedge clk);
    laps0 = 8'd2;
    req = 2'b01;
    repeat (2) @(negedge clk);
    chk("t6_laps", 32'(laps_left), 32'd2);
    chk("t6_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    req = '0;
    @(negedge clk);
    chk("t6_gnt", 32'(gnt), 32'd0);
    chk("t6_busy0", 32'(busy), 32'd0);
    chk("t6_laps0", 32'(laps_left), 32'd0);
    chk("t6_restart", 32'(fsm_restart), 32'd1);
    chk("t6_pause", 32'(fsm_pause), 32'd1);
    chk("t6_done", 32'(done), 32'd0);
    chk("t6_aborted", 32'(aborted), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("t6_fs", 32'(fs), 32'(FSM_FIRST));

    repeat (3) @(negedge clk);
    chk("sb_empty", 32'(q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d",
             n_chk, n_fail);
    $finish;
  end

endmodule
